// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Purpose : Shared types and constants for the instruction fetch front end.
//           Holds the datapath widths, the PC increment, the default reset PC,
//           the fetch state enumeration and the buffer entry layout.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Buffer entry: byte address in the upper half, instruction word below.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'(3));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Purpose : Two-entry fetch buffer between the PC/imem stage and decode.
//           The head entry lives in its own register so the consumer sees a
//           registered value; the second entry is held in a tail register and
//           shifted into the head on a pop.
// Ports   : clk       - clock, rising edge
//           reset_n   - synchronous active-low reset
//           i_push    - write i_din at the tail (ignored when full without pop)
//           i_pop     - consume the head (ignored when empty)
//           i_flush   - discard all entries; dominates push and pop
//           i_din     - entry to write {pc, instr}
//           o_head    - head entry {pc, instr}
//           o_full    - buffer holds DEPTH entries
//           o_empty   - buffer holds no entries
// -----------------------------------------------------------------------------
module fetch_fifo
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ENTRY_W-1:0] i_din,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);

    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    logic [1:0]         r_count;
    logic [ENTRY_W-1:0] r_head;
    logic [ENTRY_W-1:0] r_tail;
    logic               w_pop;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_head  = r_head;

    // A pop on an empty buffer is dropped so the count cannot underflow.
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            // Stale data may stay in the registers; only the count matters.
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_din;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && w_pop) begin
                        // Single entry replaced in place: count unchanged.
                        r_head <= i_din;
                    end else if (i_push) begin
                        r_tail  <= i_din;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a push is only accepted alongside a pop.
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_din;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Purpose : Instruction fetch front end. Holds the fetch PC, presents it to a
//           combinational instruction memory, and buffers {pc, instr} pairs in
//           a two-entry FIFO toward decode. Supports redirects (branch/jump),
//           which flush the buffer, and a halt state that stops fetching until
//           the next redirect.
// Ports   : clk            - clock, rising edge
//           reset_n        - synchronous active-low reset
//           imem_addr      - fetch byte address (equals current PC)
//           imem_data      - instruction for imem_addr, same cycle
//           redirect_valid - redirect the fetch stream this cycle
//           redirect_pc    - redirect target (low two bits dropped)
//           halt_req       - stop fetching
//           fetch_valid    - head buffer entry valid
//           fetch_ready    - decode accepts head entry
//           fetch_instr    - head entry instruction
//           fetch_pc       - head entry byte address
//           halted         - fetch unit is in HALT
// -----------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        halted
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;

    logic               w_push;
    logic               w_pop;
    logic               w_halted;
    logic               w_full;
    logic               w_empty;
    fetch_entry_t       w_din;
    fetch_entry_t       w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    // Stage boundary: PC register -> instruction memory (combinational).
    assign imem_addr   = r_pc;
    assign w_din.pc    = r_pc;
    assign w_din.instr = imem_data;

    // A redirect cancels any handshake in the same cycle.
    assign w_pop = fetch_valid && fetch_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_halted    = (r_state == HALT);
        case (r_state)
            RUN: begin
                if (redirect_valid) begin
                    w_state_nxt = RUN;
                end else if (halt_req) begin
                    w_state_nxt = HALT;
                end else begin
                    // Enqueue when there is room now or a slot frees this cycle.
                    w_push = !w_full || w_pop;
                end
            end
            HALT: begin
                // halt_req has no effect here; only a redirect resumes.
                if (redirect_valid) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= align_pc(redirect_pc);
        end else if (w_push) begin
            // Natural 32-bit wrap from FFFF_FFFC to 0000_0000.
            r_pc <= r_pc + PC_STEP;
        end
    end

    // Stage boundary: fetch buffer -> decode (registered head).
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   (w_din),
        .o_head  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head      = fetch_entry_t'(w_head_bits);
    assign fetch_valid = !w_empty;
    assign fetch_pc    = w_head.pc;
    assign fetch_instr = w_head.instr;
    assign halted      = w_halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        halted;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .halted         (halted)
    );

    // Instruction memory model: word0 / word1 fixed, others address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_4430;
        if (a == 32'h4) return 32'h0000_8610;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = mem_word(imem_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        e_valid;
        logic        e_halted;
        logic [31:0] e_addr;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic rdy, input logic redir,
                                input logic [31:0] rpc, input logic halt,
                                input logic e_valid, input logic e_halted,
                                input logic [31:0] e_addr, input logic chk_data,
                                input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rst_n = rst_n; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.halt = halt;
        v.e_valid = e_valid; v.e_halted = e_halted; v.e_addr = e_addr;
        v.chk_data = chk_data; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    localparam int NVEC = 27;
    vec_t tbl [NVEC];

    logic [31:0] exp_q [$];
    logic [31:0] nxt_pc;
    logic [31:0] exp_pc;
    logic        m_halt;
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          n_hs;

    initial begin
        // rst rdy rdr rpc halt | valid halted addr chk pc instr
        tbl[0]  = mk(0, 1, 0, 32'h0, 0,  0, 0, 32'h0,  1, 32'h0, 32'h0);
        // reset release, ready high: pc 0 then 4
        tbl[1]  = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'h4,  1, 32'h0, mem_word(32'h0));
        tbl[2]  = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'h8,  1, 32'h4, mem_word(32'h4));
        // backpressure after reset: buffer fills, pc holds at 8
        tbl[3]  = mk(0, 1, 0, 32'h0, 0,  0, 0, 32'h0,  1, 32'h0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h4,  1, 32'h0, mem_word(32'h0));
        tbl[5]  = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h8,  1, 32'h0, mem_word(32'h0));
        tbl[6]  = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h8,  1, 32'h0, mem_word(32'h0));
        tbl[7]  = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h8,  1, 32'h0, mem_word(32'h0));
        tbl[8]  = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h8,  1, 32'h0, mem_word(32'h0));
        tbl[9]  = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'hC,  1, 32'h4, mem_word(32'h4));
        tbl[10] = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'h10, 1, 32'h8, mem_word(32'h8));
        // redirect to 0x13 with full buffer
        tbl[11] = mk(1, 0, 1, 32'h13, 0, 0, 0, 32'h10, 0, 32'h0, 32'h0);
        tbl[12] = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h14, 1, 32'h10, mem_word(32'h10));
        tbl[13] = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h18, 1, 32'h10, mem_word(32'h10));
        tbl[14] = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h18, 1, 32'h10, mem_word(32'h10));
        // one-cycle halt: pc frozen, buffer drains, halt ignored while halted
        tbl[15] = mk(1, 1, 0, 32'h0, 1,  1, 1, 32'h18, 1, 32'h14, mem_word(32'h14));
        tbl[16] = mk(1, 1, 0, 32'h0, 0,  0, 1, 32'h18, 0, 32'h0, 32'h0);
        tbl[17] = mk(1, 1, 0, 32'h0, 1,  0, 1, 32'h18, 0, 32'h0, 32'h0);
        tbl[18] = mk(1, 0, 1, 32'h0, 0,  0, 0, 32'h0,  0, 32'h0, 32'h0);
        tbl[19] = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'h4,  1, 32'h0, mem_word(32'h0));
        // wrap at top of address space
        tbl[20] = mk(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        tbl[21] = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'h0,  1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        tbl[22] = mk(1, 1, 0, 32'h0, 0,  1, 0, 32'h4,  1, 32'h0, mem_word(32'h0));
        // redirect together with halt: redirect wins
        tbl[23] = mk(1, 1, 1, 32'h100, 1, 0, 0, 32'h100, 0, 32'h0, 32'h0);
        tbl[24] = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h104, 1, 32'h100, mem_word(32'h100));
        tbl[25] = mk(1, 0, 0, 32'h0, 0,  1, 0, 32'h108, 1, 32'h100, mem_word(32'h100));
        // reset mid-stream overrides redirect and halt
        tbl[26] = mk(0, 1, 1, 32'h40, 1, 0, 0, 32'h0,  1, 32'h0, 32'h0);

        reset_n        = 1'b0;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            reset_n        = tbl[i].rst_n;
            fetch_ready    = tbl[i].rdy;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            halt_req       = tbl[i].halt;
            @(posedge clk);
            #1;
            chk32($sformatf("v%0d.valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_valid});
            chk32($sformatf("v%0d.halted", i), {31'b0, halted}, {31'b0, tbl[i].e_halted});
            chk32($sformatf("v%0d.imem_addr", i), imem_addr, tbl[i].e_addr);
            if (tbl[i].chk_data) begin
                chk32($sformatf("v%0d.fetch_pc", i), fetch_pc, tbl[i].e_pc);
                chk32($sformatf("v%0d.fetch_instr", i), fetch_instr, tbl[i].e_instr);
            end
        end

        // Random stream: the last vector left the unit freshly reset.
        exp_q.delete();
        nxt_pc     = 32'h0;
        m_halt     = 1'b0;
        prev_stall = 1'b0;
        prev_pc    = 32'h0;
        prev_instr = 32'h0;
        n_hs       = 0;
        for (int c = 0; c < 400; c++) begin
            reset_n        = 1'b1;
            fetch_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            halt_req       = ($urandom_range(0, 24) == 0);
            if (redirect_valid) begin
                exp_q.delete();
                nxt_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back(nxt_pc);
                nxt_pc = nxt_pc + 32'd4;
            end

            @(negedge clk);
            chk32("sb.halted", {31'b0, halted}, {31'b0, m_halt});
            if (prev_stall) begin
                chk32("sb.hold_pc", fetch_pc, prev_pc);
                chk32("sb.hold_instr", fetch_instr, prev_instr);
            end
            if (!redirect_valid && fetch_valid && fetch_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb.underflow actual=handshake required=none");
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk32("sb.fetch_pc", fetch_pc, exp_pc);
                    chk32("sb.fetch_instr", fetch_instr, mem_word(exp_pc));
                end
            end
            prev_stall = !redirect_valid && fetch_valid && !fetch_ready;
            prev_pc    = fetch_pc;
            prev_instr = fetch_instr;
            if (redirect_valid) m_halt = 1'b0;
            else if (halt_req) m_halt = 1'b1;

            @(posedge clk);
            #1;
        end

        total++;
        if (n_hs < 20) begin
            bad++;
            $display("FAIL sb.handshakes actual=%0d required=>=20", n_hs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2: fetch buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 imem_addr  output  32  byte address driven to instruction memory program_counter.
REQ-006 imem_data  input  32  combinational instruction returned for imem_addr, same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 halt_req  input  1  request to stop fetching.
REQ-010 fetch_valid  output  1  head buffer entry valid toward decode.
REQ-011 fetch_ready  input  1  decode accepts head entry this cycle.
REQ-012 fetch_instr  output  32  head entry instruction.
REQ-013 fetch_pc  output  32  head entry byte address.
REQ-014 halted  output  1  high while in state HALT.

Function
REQ-015 pc_q SHALL be the current fetch address; imem_addr SHALL equal pc_q combinationally.
REQ-016 State machine SHALL have states RUN and HALT.
REQ-017 RUN->HALT when halt_req=1 and redirect_valid=0; HALT->RUN only on redirect_valid=1; halt_req ignored while in HALT.
REQ-018 Enqueue condition: state RUN, redirect_valid=0, halt_req=0, and (count<2 or pop this cycle).
REQ-019 On enqueue, {pc_q, imem_data} SHALL be written to the tail, and pc_q SHALL become pc_q+4, modulo 2^32 (wrap 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Pop SHALL occur when fetch_valid=1 and fetch_ready=1; the head entry advances next cycle.
REQ-021 fetch_valid SHALL equal (count!=0); fetch_instr/fetch_pc SHALL be driven from the head register (registered outputs, 1-cycle fetch-to-valid latency).
REQ-022 Full (count=2) with no pop: no enqueue, pc_q holds.
REQ-023 Full with pop: enqueue and pop in the same cycle; count stays 2.
REQ-024 Empty with fetch_ready=1: no pop, no underflow.
REQ-025 redirect_valid=1 SHALL take priority over all else: buffer flushed (count=0), pc_q <= {redirect_pc[31:2],2'b00}, no enqueue, pop ignored; fetch_valid=0 in the following cycle.
REQ-026 Simultaneous redirect_valid and halt_req: redirect wins, state RUN.
REQ-027 Fetch data SHALL not change while fetch_valid=1 and fetch_ready=0.

Reset
REQ-028 On reset_n=0 at a clock edge: pc_q=RESET_PC, count=0, state=RUN, fetch_valid=0, halted=0, fetch_instr=0, fetch_pc=0.
REQ-029 Reset SHALL override redirect, halt and handshakes; in-flight entries are discarded.
REQ-030 First enqueue SHALL occur on the first edge with reset_n=1, fetching RESET_PC.

Structure
REQ-031 Shared package SHALL hold INSTR_W=32, ADDR_W=32, PC_STEP=4, RESET_PC default and the fetch state enum (RUN, HALT).
REQ-032 The 2-entry buffer SHALL be a sub-module fetch_fifo with push/pop/flush, full/empty, synchronous active-low reset.

Verification
REQ-033 Reset release with memory word0=32'h00004430, word1=32'h00008610, fetch_ready=1 -> cycle1 fetch_pc=0/instr 00004430, cycle2 fetch_pc=4/instr 00008610.
REQ-034 fetch_ready=0 for 5 cycles after reset -> count saturates at 2, pc_q holds at 8, head stays pc 0; first accept resumes with pc 4 then 8.
REQ-035 redirect_valid=1, redirect_pc=32'h0000_0013 with buffer full -> next cycle fetch_valid=0, imem_addr=32'h10; following cycle fetch_pc=32'h10.
REQ-036 halt_req=1 for one cycle -> halted=1, pc_q frozen, buffer drains; redirect_pc=0 -> halted=0, fetching restarts at 0.
REQ-037 redirect_pc=32'hFFFF_FFFC -> fetch_pc sequence FFFF_FFFC then 0000_0000.
REQ-038 reset_n=0 mid-stream with full buffer -> next cycle fetch_valid=0, imem_addr=RESET_PC, halted=0.
